// File: rtl/sram_pkg.sv
// Shared types and helpers for the simple-dual-port SRAM.
// Provides the FSM state type, read-during-write mode codes and the byte-lane merge.
package sram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } sram_state_t;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    // Widest data word the merge helper supports; callers size-cast in and out.
    localparam int MERGE_W = 256;

    function automatic logic [MERGE_W-1:0] be_merge(
        input logic [MERGE_W-1:0]   old_w,
        input logic [MERGE_W-1:0]   new_w,
        input logic [MERGE_W/8-1:0] be
    );
        logic [MERGE_W-1:0] res;
        res = old_w;
        for (int i = 0; i < MERGE_W/8; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-response pipeline: carries valid, error flag and data RD_LAT stages deep.
// Data registers only load on a valid beat so rdData holds between reads.
module sram_rd_pipe #(
    parameter int DAT    = 8,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_vld,
    input  logic           in_err,
    input  logic [DAT-1:0] in_data,
    output logic           rdValid,
    output logic           rdErr,
    output logic [DAT-1:0] rdData
);

    logic           vld_p0;
    logic           err_p0;
    logic [DAT-1:0] data_p0;

    // Stage p0: array read result captured on the accepting edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            err_p0  <= 1'b0;
            data_p0 <= '0;
        end else begin
            vld_p0 <= in_vld;
            err_p0 <= in_vld & in_err;
            if (in_vld) data_p0 <= in_data;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic           vld_p1;
            logic           err_p1;
            logic [DAT-1:0] data_p1;

            // Stage p1: optional output register
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_p1  <= 1'b0;
                    err_p1  <= 1'b0;
                    data_p1 <= '0;
                end else begin
                    vld_p1 <= vld_p0;
                    err_p1 <= err_p0;
                    if (vld_p0) data_p1 <= data_p0;
                end
            end

            assign rdValid = vld_p1;
            assign rdErr   = err_p1;
            assign rdData  = data_p1;
        end else begin : g_lat1
            assign rdValid = vld_p0;
            assign rdErr   = err_p0;
            assign rdData  = data_p0;
        end
    endgenerate

endmodule

// File: rtl/sync_ram_dp.sv
// Simple-dual-port synchronous SRAM with byte enables, 1/2-cycle read latency,
// selectable read-during-write policy and a hardware clear sweep after reset.
module sync_ram_dp
    import sram_pkg::*;
#(
    parameter int             ADR      = 8,
    parameter int             DAT      = 8,
    parameter int             DPTH     = 256,
    parameter int             RD_LAT   = 1,
    parameter int             RDW_MODE = 0,
    parameter logic [DAT-1:0] INIT_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clrReq,
    input  logic             wrEn,
    input  logic [ADR-1:0]   wrAddr,
    input  logic [DAT-1:0]   wrData,
    input  logic [DAT/8-1:0] wrBe,
    input  logic             rdEn,
    input  logic [ADR-1:0]   rdAddr,
    output logic [DAT-1:0]   rdData,
    output logic             rdValid,
    output logic             rdErr,
    output logic             busy
);

    generate
        if ((DAT % 8) != 0 || DAT < 8 || DAT > MERGE_W) begin : g_bad_dat
            $error("sync_ram_dp: DAT must be a multiple of 8 in 8..%0d", MERGE_W);
        end
        if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
            $error("sync_ram_dp: RD_LAT must be 1 or 2");
        end
        if (DPTH < 1 || DPTH > (2**ADR)) begin : g_bad_dpth
            $error("sync_ram_dp: DPTH must be in 1..2**ADR");
        end
    endgenerate

    localparam int           IW      = (DPTH > 1) ? $clog2(DPTH) : 1;
    localparam logic [ADR:0] DEPTH_C = (ADR+1)'(DPTH);
    localparam logic [ADR:0] LAST_C  = (ADR+1)'(DPTH - 1);

    logic [DAT-1:0] mem [DPTH];

    sram_state_t    state;
    logic [ADR:0]   cnt;
    logic           wr_ok;
    logic           rd_acc;
    logic           rd_oob;
    logic           wr_hit;
    logic [DAT-1:0] rd_word;

    assign wr_ok  = wrEn & ~busy & ({1'b0, wrAddr} < DEPTH_C);
    assign rd_acc = rdEn & ~busy;
    assign rd_oob = ({1'b0, rdAddr} >= DEPTH_C);
    assign wr_hit = wr_ok & (wrAddr == rdAddr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (cnt == LAST_C) begin
                        state <= READY;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READY: begin
                    if (clrReq) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    busy  <= 1'b1;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Array write port: the sweep owns the array while clearing
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[cnt[IW-1:0]] <= INIT_VAL;
        end else if (wr_ok) begin
            for (int i = 0; i < DAT/8; i++) begin
                if (wrBe[i]) mem[wrAddr[IW-1:0]][8*i +: 8] <= wrData[8*i +: 8];
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (!rd_oob) begin
            rd_word = mem[rdAddr[IW-1:0]];
            // Write-first forwards the enabled lanes of the concurrent write
            if (RDW_MODE == RDW_WRITE_FIRST && wr_hit) begin
                rd_word = DAT'(be_merge(MERGE_W'(mem[rdAddr[IW-1:0]]),
                                        MERGE_W'(wrData),
                                        (MERGE_W/8)'(wrBe)));
            end
        end
    end

    sram_rd_pipe #(
        .DAT    (DAT),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (rd_acc),
        .in_err  (rd_oob),
        .in_data (rd_word),
        .rdValid (rdValid),
        .rdErr   (rdErr),
        .rdData  (rdData)
    );

endmodule

// File: tb/tb_sync_ram_dp.sv
// Scoreboard bench for sync_ram_dp: two instances cover both latencies,
// both read-during-write modes, a non-power-of-two depth and the clear sweep.
module tb_sync_ram_dp;

    localparam int          A_LAT  = 2;
    localparam int          B_LAT  = 1;
    localparam logic [31:0] A_INIT = 32'h0F0F_0F0F;
    localparam logic [7:0]  B_INIT = 8'hC3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Instance A: ADR=4, DAT=32, DPTH=12, RD_LAT=2, write-first
    logic        a_clr = 1'b0, a_we = 1'b0, a_re = 1'b0;
    logic [3:0]  a_wa = '0, a_ra = '0, a_be = '0;
    logic [31:0] a_wd = '0;
    logic [31:0] a_rdata;
    logic        a_rv, a_err, a_busy;

    // Instance B: ADR=4, DAT=8, DPTH=16, RD_LAT=1, read-first
    logic        b_clr = 1'b0, b_we = 1'b0, b_re = 1'b0;
    logic [3:0]  b_wa = '0, b_ra = '0;
    logic [0:0]  b_be = '0;
    logic [7:0]  b_wd = '0;
    logic [7:0]  b_rdata;
    logic        b_rv, b_err, b_busy;

    sync_ram_dp #(
        .ADR(4), .DAT(32), .DPTH(12), .RD_LAT(A_LAT), .RDW_MODE(1), .INIT_VAL(A_INIT)
    ) u_a (
        .clk(clk), .rst(rst), .clrReq(a_clr),
        .wrEn(a_we), .wrAddr(a_wa), .wrData(a_wd), .wrBe(a_be),
        .rdEn(a_re), .rdAddr(a_ra),
        .rdData(a_rdata), .rdValid(a_rv), .rdErr(a_err), .busy(a_busy)
    );

    sync_ram_dp #(
        .ADR(4), .DAT(8), .DPTH(16), .RD_LAT(B_LAT), .RDW_MODE(0), .INIT_VAL(B_INIT)
    ) u_b (
        .clk(clk), .rst(rst), .clrReq(b_clr),
        .wrEn(b_we), .wrAddr(b_wa), .wrData(b_wd), .wrBe(b_be),
        .rdEn(b_re), .rdAddr(b_ra),
        .rdData(b_rdata), .rdValid(b_rv), .rdErr(b_err), .busy(b_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic bad(input string name, input logic [31:0] info);
        n_chk++;
        $display("FAIL %s: info 0x%0h (cycle %0d)", name, info, cyc);
    endtask

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          c;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    // Monitors: pop an expectation whenever a read response appears
    always @(negedge clk) begin
        exp_t e;
        if (a_rv === 1'b1) begin
            if (qa.size() == 0) begin
                bad("A_unexpected_rdValid", a_rdata);
            end else begin
                e = qa.pop_front();
                chk("A_rdData", a_rdata, e.d);
                chk("A_rdErr", 32'(a_err), 32'(e.e));
                chk("A_latency", 32'(cyc), 32'(e.c));
            end
        end else if (qa.size() > 0 && cyc >= qa[0].c) begin
            e = qa.pop_front();
            bad("A_missing_rdValid", e.d);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (b_rv === 1'b1) begin
            if (qb.size() == 0) begin
                bad("B_unexpected_rdValid", 32'(b_rdata));
            end else begin
                e = qb.pop_front();
                chk("B_rdData", 32'(b_rdata), e.d);
                chk("B_rdErr", 32'(b_err), 32'(e.e));
                chk("B_latency", 32'(cyc), 32'(e.c));
            end
        end else if (qb.size() > 0 && cyc >= qb[0].c) begin
            e = qb.pop_front();
            bad("B_missing_rdValid", e.d);
        end
    end

    task automatic a_op(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic [3:0] be, input logic re, input logic [3:0] ra,
                        input logic push, input logic [31:0] exp_d, input logic exp_e);
        @(negedge clk);
        a_we = we; a_wa = wa; a_wd = wd; a_be = be; a_re = re; a_ra = ra;
        if (push) qa.push_back('{d: exp_d, e: exp_e, c: cyc + A_LAT});
    endtask

    task automatic b_op(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                        input logic be, input logic re, input logic [3:0] ra,
                        input logic push, input logic [7:0] exp_d, input logic exp_e);
        @(negedge clk);
        b_we = we; b_wa = wa; b_wd = wd; b_be = be; b_re = re; b_ra = ra;
        if (push) qb.push_back('{d: 32'(exp_d), e: exp_e, c: cyc + B_LAT});
    endtask

    task automatic a_write(input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] be);
        a_op(1'b1, wa, wd, be, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic a_read(input logic [3:0] ra, input logic [31:0] exp_d, input logic exp_e);
        a_op(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, ra, 1'b1, exp_d, exp_e);
    endtask

    task automatic a_idle();
        a_op(1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic b_write(input logic [3:0] wa, input logic [7:0] wd, input logic be);
        b_op(1'b1, wa, wd, be, 1'b0, 4'd0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic b_read(input logic [3:0] ra, input logic [7:0] exp_d);
        b_op(1'b0, 4'd0, 8'd0, 1'b0, 1'b1, ra, 1'b1, exp_d, 1'b0);
    endtask

    task automatic b_idle();
        b_op(1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic chk_reset_outputs();
        chk("A_rst_rdData", a_rdata, 32'd0);
        chk("A_rst_rdValid", 32'(a_rv), 32'd0);
        chk("A_rst_rdErr", 32'(a_err), 32'd0);
        chk("A_rst_busy", 32'(a_busy), 32'd1);
        chk("B_rst_rdData", 32'(b_rdata), 32'd0);
        chk("B_rst_rdValid", 32'(b_rv), 32'd0);
        chk("B_rst_rdErr", 32'(b_err), 32'd0);
        chk("B_rst_busy", 32'(b_busy), 32'd1);
    endtask

    // Called on the negedge where rst is released; counts busy cycles of both instances
    task automatic wait_ready();
        int ca = 0;
        int cb = 0;
        for (int i = 0; i < 100 && (a_busy || b_busy); i++) begin
            if (a_busy) ca++;
            if (b_busy) cb++;
            @(negedge clk);
        end
        chk("A_busy_cycles", 32'(ca), 32'd12);
        chk("B_busy_cycles", 32'(cb), 32'd16);
    endtask

    function automatic logic [31:0] a_after_writes(input int addr);
        case (addr)
            3:       return 32'hAA22_CC44;
            5:       return 32'h0000_0099;
            default: return A_INIT;
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        wait_ready();

        // B: post-sweep contents, then read-first collisions
        for (int i = 0; i < 16; i++) b_read(4'(i), B_INIT);
        b_write(4'd5, 8'h10, 1'b1);
        b_op(1'b1, 4'd5, 8'h55, 1'b1, 1'b1, 4'd5, 1'b1, 8'h10, 1'b0);
        b_read(4'd5, 8'h55);
        b_write(4'd6, 8'hAA, 1'b0);
        b_read(4'd6, B_INIT);
        b_op(1'b1, 4'd7, 8'h77, 1'b1, 1'b1, 4'd6, 1'b1, B_INIT, 1'b0);
        b_read(4'd7, 8'h77);
        b_idle();

        // A: post-sweep contents, byte lanes, write-first, out-of-range
        for (int i = 0; i < 12; i++) a_read(4'(i), A_INIT, 1'b0);
        a_write(4'd3, 32'hAABB_CCDD, 4'b1111);
        a_write(4'd3, 32'h1122_3344, 4'b0101);
        a_read(4'd3, 32'hAA22_CC44, 1'b0);
        a_write(4'd5, 32'h0000_0010, 4'b1111);
        a_op(1'b1, 4'd5, 32'h0000_0055, 4'b1111, 1'b1, 4'd5, 1'b1, 32'h0000_0055, 1'b0);
        a_read(4'd5, 32'h0000_0055, 1'b0);
        a_op(1'b1, 4'd5, 32'hFFFF_FF99, 4'b0001, 1'b1, 4'd5, 1'b1, 32'h0000_0099, 1'b0);
        a_read(4'd13, 32'd0, 1'b1);
        a_read(4'd15, 32'd0, 1'b1);
        a_write(4'd14, 32'hDEAD_BEEF, 4'b1111);
        for (int i = 0; i < 12; i++) a_read(4'(i), a_after_writes(i), 1'b0);
        a_idle();

        // A: clear request with a read in flight, then reset mid-sweep
        a_write(4'd7, 32'h1234_5678, 4'b1111);
        a_read(4'd7, 32'h1234_5678, 1'b0);
        a_clr = 1'b1;
        a_op(1'b1, 4'd8, 32'hCAFE_F00D, 4'b1111, 1'b1, 4'd2, 1'b0, 32'd0, 1'b0);
        a_clr = 1'b0;
        chk("A_busy_after_clrReq", 32'(a_busy), 32'd1);
        repeat (3) a_op(1'b1, 4'd8, 32'hCAFE_F00D, 4'b1111, 1'b1, 4'd2, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        a_we = 1'b0;
        a_re = 1'b0;
        rst  = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        wait_ready();
        for (int i = 0; i < 12; i++) a_read(4'(i), A_INIT, 1'b0);
        a_idle();
        b_read(4'd5, B_INIT);
        b_idle();

        // A: a read still in the pipeline when reset hits must never appear
        a_op(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd4, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        a_re = 1'b0;
        rst  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_ready();
        repeat (5) @(negedge clk);

        chk("A_queue_drained", 32'(qa.size()), 32'd0);
        chk("B_queue_drained", 32'(qb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
